// File: rtl/show_sequencer_if.sv
// Button/program inputs and effect-unit handshake for the show sequencer.
interface show_sequencer_if;
   logic [3:0]  btn_req;
   logic [63:0] prog;
   logic        op_ready;
   logic [3:0]  btn_gnt;
   logic        op_valid;
   logic [3:0]  op_code;
   logic [1:0]  slot;
   logic        busy;
   logic        done;

   // Sequencer side: consumes requests/programs and drives the effect unit.
   modport master (
      input  btn_req, prog, op_ready,
      output btn_gnt, op_valid, op_code, slot, busy, done
   );

   // Surrounding logic side: drives requests/programs and accepts opcodes.
   modport slave (
      output btn_req, prog, op_ready,
      input  btn_gnt, op_valid, op_code, slot, busy, done
   );
endinterface

// File: rtl/show_sequencer.sv
// Round-robin arbitrates four buttons, latches the winner's 4-slot program
// and steps it through the shared effect unit with a dwell after each effect.
module show_sequencer #(
   parameter int unsigned DWELL = 4
) (
   input  logic               clk,
   input  logic               rst,
   show_sequencer_if.master   sif
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned PROG_W = 16;
   localparam int unsigned NBTN   = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DWELL = 2'd2
   } state_t;

   // Opcodes that are handed to the effect unit.
   function automatic logic op_is_effect(input logic [3:0] op);
      case (op)
         4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD: return 1'b1;
         default:                                             return 1'b0;
      endcase
   endfunction

   function automatic logic op_is_noop(input logic [3:0] op);
      return op == 4'h2;
   endfunction

   function automatic logic op_is_abort(input logic [3:0] op);
      return op == 4'h1;
   endfunction

   state_t              r_state;
   logic [PROG_W-1:0]   r_prog;
   logic [1:0]          r_slot;
   logic [CNT_W-1:0]    r_cnt;
   logic [1:0]          r_last_grant;
   logic [NBTN-1:0]     r_btn_gnt;
   logic                r_op_valid;
   logic [OP_W-1:0]     r_op_code;
   logic                r_done;

   logic                w_any_req;
   logic [1:0]          w_gnt_idx;
   logic [PROG_W-1:0]   w_gnt_prog;
   logic [OP_W-1:0]     w_next_op;
   logic                w_last_slot;
   logic                w_skip;
   logic                w_advance;

   // Round-robin pick: first set request searching upward from last_grant+1.
   always_comb begin
      w_gnt_idx = r_last_grant;
      for (int k = NBTN; k >= 1; k--) begin
         if (sif.btn_req[2'(r_last_grant + 2'(k))]) begin
            w_gnt_idx = 2'(r_last_grant + 2'(k));
         end
      end
   end

   assign w_any_req   = |sif.btn_req;
   assign w_gnt_prog  = sif.prog[{w_gnt_idx, 4'b0000} +: PROG_W];
   assign w_next_op   = r_prog[{2'(r_slot + 2'd1), 2'b00} +: OP_W];
   assign w_last_slot = (r_slot == 2'd3);
   assign w_skip      = !op_is_effect(r_op_code) && !op_is_noop(r_op_code) &&
                        !op_is_abort(r_op_code);

   // Slot advance: skip opcodes leave ISSUE at once, dwell leaves at count 1.
   assign w_advance = ((r_state == S_ISSUE) && w_skip) ||
                      ((r_state == S_DWELL) && (r_cnt == CNT_W'(1)));

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_prog       <= '0;
         r_slot       <= '0;
         r_cnt        <= '0;
         r_last_grant <= 2'd3;
         r_btn_gnt    <= '0;
         r_op_valid   <= 1'b0;
         r_op_code    <= '0;
         r_done       <= 1'b0;
      end else begin
         r_btn_gnt <= '0;
         r_done    <= 1'b0;
         if (w_advance) begin
            r_cnt <= '0;
            if (w_last_slot) begin
               r_state    <= S_IDLE;
               r_slot     <= '0;
               r_op_code  <= r_prog[OP_W-1:0];
               r_op_valid <= 1'b0;
               r_done     <= 1'b1;
            end else begin
               r_state    <= S_ISSUE;
               r_slot     <= 2'(r_slot + 2'd1);
               r_op_code  <= w_next_op;
               r_op_valid <= op_is_effect(w_next_op);
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_any_req) begin
                     r_state      <= S_ISSUE;
                     r_prog       <= w_gnt_prog;
                     r_last_grant <= w_gnt_idx;
                     r_slot       <= '0;
                     r_op_code    <= w_gnt_prog[OP_W-1:0];
                     r_op_valid   <= op_is_effect(w_gnt_prog[OP_W-1:0]);
                     r_btn_gnt    <= NBTN'(4'b0001 << w_gnt_idx);
                  end
               end
               S_ISSUE: begin
                  if (op_is_effect(r_op_code)) begin
                     // Hold opcode until the effect unit takes it.
                     if (sif.op_ready) begin
                        r_op_valid <= 1'b0;
                        r_state    <= S_DWELL;
                        r_cnt      <= CNT_W'(DWELL);
                     end
                  end else if (op_is_noop(r_op_code)) begin
                     r_state <= S_DWELL;
                     r_cnt   <= CNT_W'(DWELL);
                  end else begin
                     // RESET opcode: drop the rest of the program.
                     r_state    <= S_IDLE;
                     r_slot     <= '0;
                     r_op_code  <= r_prog[OP_W-1:0];
                     r_op_valid <= 1'b0;
                     r_done     <= 1'b1;
                  end
               end
               S_DWELL: begin
                  r_cnt <= CNT_W'(r_cnt - CNT_W'(1));
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign sif.btn_gnt  = r_btn_gnt;
   assign sif.op_valid = r_op_valid;
   assign sif.op_code  = r_op_code;
   assign sif.slot     = r_slot;
   assign sif.busy     = (r_state != S_IDLE);
   assign sif.done     = r_done;

endmodule

// File: tb/tb_show_sequencer.sv
// Scoreboard bench for show_sequencer: expected grants, issues and done
// pulses are queued when a request is driven and matched as they appear.
module tb_show_sequencer;

   localparam int unsigned DWELL  = 4;
   localparam int          BUDGET = 300;

   typedef struct {
      int         cyc;
      logic [1:0] slot;
      logic [3:0] op;
   } op_exp_t;

   typedef struct {
      int         cyc;
      logic [3:0] gnt;
   } gnt_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   op_exp_t  op_q[$];
   gnt_exp_t gnt_q[$];
   int       done_q[$];
   op_exp_t  mon_op;
   gnt_exp_t mon_gnt;
   int       mon_done;

   show_sequencer_if u_if ();

   show_sequencer #(.DWELL(DWELL)) dut (
      .clk (clk),
      .rst (rst),
      .sif (u_if.master)
   );

   always #5 clk = ~clk;

   // Cycle n spans posedge n to posedge n+1.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // 0 effect, 1 noop, 2 abort, 3 skip.
   function automatic int op_class(input logic [3:0] op);
      case (op)
         4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD: return 0;
         4'h2:    return 1;
         4'h1:    return 2;
         default: return 3;
      endcase
   endfunction

   // Queue the expected behaviour of one program whose request is sampled in cycle t.
   task automatic expect_prog(input int t, input int btn, input logic [15:0] p,
                              input int stall0, output int done_cyc);
      int         c;
      logic [3:0] op;
      bit         stop;
      c    = t + 1;
      stop = 1'b0;
      gnt_q.push_back('{t + 1, 4'(1 << btn)});
      for (int s = 0; s < 4; s++) begin
         if (!stop) begin
            op = p[4*s +: 4];
            case (op_class(op))
               0: begin
                  if (s == 0) c += stall0;
                  op_q.push_back('{c, 2'(s), op});
                  c += 1 + DWELL;
               end
               1:       c += 1 + DWELL;
               2: begin c += 1; stop = 1'b1; end
               default: c += 1;
            endcase
         end
      end
      done_q.push_back(c);
      done_cyc = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((op_q.size() + gnt_q.size() + done_q.size()) != 0 && n < BUDGET) begin
         tick();
         n++;
      end
      check_eq(tag, op_q.size() + gnt_q.size() + done_q.size(), 0);
      repeat (2) tick();
   endtask

   // One program with optional op_ready stall on slot 0; called in an IDLE cycle.
   task automatic run_prog(input string tag, input logic [3:0] req, input int btn,
                           input logic [15:0] p, input int stall);
      int t;
      int d;
      u_if.prog[16*btn +: 16] = p;
      u_if.btn_req = req;
      t = cyc;
      expect_prog(t, btn, p, stall, d);
      tick();
      u_if.btn_req = 4'b0000;
      if (stall > 0) begin
         u_if.op_ready = 1'b0;
         repeat (stall) tick();
         u_if.op_ready = 1'b1;
      end
      wait_drain(tag);
   endtask

   // Scoreboard monitor, sampling mid-cycle.
   always @(negedge clk) begin
      if (u_if.btn_gnt != 4'b0000) begin
         if (gnt_q.size() == 0) begin
            check_eq("gnt_unexpected", u_if.btn_gnt, 0);
         end else begin
            mon_gnt = gnt_q.pop_front();
            check_eq("gnt_value", u_if.btn_gnt, mon_gnt.gnt);
            check_eq("gnt_cycle", cyc, mon_gnt.cyc);
            check_eq("busy_at_gnt", u_if.busy, 1);
         end
      end
      if (u_if.op_valid === 1'b1) begin
         if (op_q.size() == 0) begin
            check_eq("op_valid_unexpected", u_if.op_valid, 0);
         end else begin
            check_eq("op_code", u_if.op_code, op_q[0].op);
            check_eq("op_slot", u_if.slot, op_q[0].slot);
            if (u_if.op_ready) begin
               mon_op = op_q.pop_front();
               check_eq("issue_cycle", cyc, mon_op.cyc);
            end
         end
      end
      if (u_if.done === 1'b1) begin
         if (done_q.size() == 0) begin
            check_eq("done_unexpected", u_if.done, 0);
         end else begin
            mon_done = done_q.pop_front();
            check_eq("done_cycle", cyc, mon_done);
            check_eq("busy_at_done", u_if.busy, 0);
         end
      end
   end

   logic [15:0] arb_prog [4];

   initial begin
      int t;
      int t_last;
      int d;
      int n;
      u_if.btn_req  = 4'b1111;
      u_if.prog     = '0;
      u_if.op_ready = 1'b1;
      rst           = 1'b0;

      // Reset held with every button requesting.
      repeat (2) begin
         tick();
         check_eq("rst_gnt", u_if.btn_gnt, 0);
         check_eq("rst_op_valid", u_if.op_valid, 0);
         check_eq("rst_op_code", u_if.op_code, 0);
         check_eq("rst_slot", u_if.slot, 0);
         check_eq("rst_busy", u_if.busy, 0);
         check_eq("rst_done", u_if.done, 0);
      end

      // Arbitration: all requests held, grants rotate from button 0.
      arb_prog[0] = 16'h0000;
      arb_prog[1] = 16'h77D7;
      arb_prog[2] = 16'h1003;
      arb_prog[3] = 16'hB1EF;
      for (int b = 0; b < 4; b++) u_if.prog[16*b +: 16] = arb_prog[b];
      rst = 1'b1;
      t = cyc;
      t_last = t;
      for (int k = 0; k < 5; k++) begin
         t_last = t;
         expect_prog(t, k % 4, arb_prog[k % 4], 0, d);
         t = d;
      end
      n = 0;
      while (cyc < t_last + 1 && n < BUDGET) begin
         tick();
         n++;
      end
      u_if.btn_req = 4'b0000;
      wait_drain("arb_drain");

      run_prog("single_drain", 4'b0001, 0, 16'h3458, 0);
      run_prog("backpressure_drain", 4'b0001, 0, 16'h3458, 3);
      run_prog("abort_drain", 4'b0010, 1, 16'hA412, 0);
      run_prog("skip_drain", 4'b1000, 3, 16'hF0C7, 0);

      // Reset while slot 2 is being offered.
      u_if.prog[32 +: 16] = 16'h3458;
      u_if.btn_req = 4'b0100;
      t = cyc;
      expect_prog(t, 2, 16'h3458, 0, d);
      tick();
      u_if.btn_req = 4'b0000;
      repeat (10) tick();
      u_if.op_ready = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      u_if.op_ready = 1'b1;
      op_q.delete();
      gnt_q.delete();
      done_q.delete();
      check_eq("midrst_op_valid", u_if.op_valid, 0);
      check_eq("midrst_busy", u_if.busy, 0);
      check_eq("midrst_slot", u_if.slot, 0);
      check_eq("midrst_done", u_if.done, 0);
      check_eq("midrst_op_code", u_if.op_code, 0);
      repeat (30) tick();

      // After reset button 0 again has top priority over button 3.
      run_prog("post_rst_drain", 4'b1001, 0, 16'h2003, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
